// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: table sizes, tag width and
// the encoding of the 2-bit saturating direction counters.
package branch_predictor_pkg;

   localparam int BTB_IDX_W_DEF = 6;
   localparam int BHT_IDX_W_DEF = 8;
   localparam int PC_W          = 32;

   // Tag is everything above the BTB index and the ignored byte offset.
   function automatic int tag_width(input int btb_idx_w);
      return PC_W - btb_idx_w - 2;
   endfunction

   localparam int TAG_W_DEF = tag_width(BTB_IDX_W_DEF);

   typedef enum logic [1:0] {
      CNT_SNT = 2'b00,
      CNT_WNT = 2'b01,
      CNT_WT  = 2'b10,
      CNT_ST  = 2'b11
   } cnt2_e;

endpackage

// File: rtl/branch_predictor_sat_cnt2.sv
// Next-state logic for one 2-bit saturating direction counter.
module sat_cnt2
   import branch_predictor_pkg::*;
(
   input  cnt2_e cnt,
   input  logic  taken,
   output cnt2_e next
);

   // Step toward taken/not-taken, holding at either end of the range.
   always_comb begin
      next = cnt;
      if (taken) begin
         if (cnt != CNT_ST) next = cnt2_e'(cnt + 2'd1);
      end else begin
         if (cnt != CNT_SNT) next = cnt2_e'(cnt - 2'd1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Zero-latency branch predictor: direct-mapped BTB with full tags plus an
// independently indexed table of 2-bit counters. Lookups read the register
// arrays combinationally; updates from EX land on the clock edge, so a
// same-cycle lookup always sees the pre-update contents.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int BTB_IDX_W = BTB_IDX_W_DEF,
   parameter int BHT_IDX_W = BHT_IDX_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC_IF,
   output logic        predict_br_IF,
   output logic        BHT_predict_IF,
   output logic [31:0] PC_pred_IF,
   input  logic        update_en_EX,
   input  logic [31:0] PC_EX,
   input  logic        br_taken_EX,
   input  logic [31:0] br_target_EX,
   input  logic        predict_br_EX,
   output logic        mispredict_EX,
   output logic [31:0] PC_redirect_EX
);

   localparam int TAG_W       = tag_width(BTB_IDX_W);
   localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
   localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

   logic              valid_q  [BTB_ENTRIES];
   logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
   logic [31:0]       target_q [BTB_ENTRIES];
   cnt2_e             bht_q    [BHT_ENTRIES];

   logic [BTB_IDX_W-1:0] btb_idx_if, btb_idx_ex;
   logic [TAG_W-1:0]     tag_if, tag_ex;
   logic [BHT_IDX_W-1:0] bht_idx_if, bht_idx_ex;
   logic                 btb_hit_if;
   logic                 do_update;
   cnt2_e                cnt_d;

   // Byte-offset bits carry no information for word-aligned fetch.
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^{PC_IF[1:0], PC_EX[1:0]};

   assign btb_idx_if = PC_IF[BTB_IDX_W+1:2];
   assign tag_if     = PC_IF[31:BTB_IDX_W+2];
   assign bht_idx_if = PC_IF[BHT_IDX_W+1:2];

   assign btb_idx_ex = PC_EX[BTB_IDX_W+1:2];
   assign tag_ex     = PC_EX[31:BTB_IDX_W+2];
   assign bht_idx_ex = PC_EX[BHT_IDX_W+1:2];

   // Reset wins over a coincident update; that update is dropped.
   assign do_update = update_en_EX && !rst;

   // Fetch-side prediction straight from current table contents.
   always_comb begin
      btb_hit_if     = valid_q[btb_idx_if] && (tag_q[btb_idx_if] == tag_if);
      BHT_predict_IF = bht_q[bht_idx_if][1];
      predict_br_IF  = btb_hit_if && BHT_predict_IF;
      PC_pred_IF     = predict_br_IF ? target_q[btb_idx_if] : (PC_IF + 32'd4);
   end

   // Resolution in EX: flush when the carried prediction disagrees with the outcome.
   always_comb begin
      mispredict_EX  = update_en_EX && (predict_br_EX ^ br_taken_EX);
      PC_redirect_EX = br_taken_EX ? br_target_EX : (PC_EX + 32'd4);
   end

   sat_cnt2 u_sat_cnt2 (
      .cnt   (bht_q[bht_idx_ex]),
      .taken (br_taken_EX),
      .next  (cnt_d)
   );

   // Valid bits: cleared on reset, set when a taken branch allocates its entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (update_en_EX && br_taken_EX) begin
         valid_q[btb_idx_ex] <= 1'b1;
      end
   end

   // Tag/target payload needs no reset; it is only trusted behind a valid bit.
   always_ff @(posedge clk) begin
      if (do_update && br_taken_EX) begin
         tag_q[btb_idx_ex]    <= tag_ex;
         target_q[btb_idx_ex] <= br_target_EX;
      end
   end

   // Direction counters: reset to weakly not-taken, then train on every resolved branch.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_WNT;
      end else if (update_en_EX) begin
         bht_q[bht_idx_ex] <= cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// checked against a behavioural table model kept in plain int arrays.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PC_IF;
   logic        predict_br_IF;
   logic        BHT_predict_IF;
   logic [31:0] PC_pred_IF;
   logic        update_en_EX;
   logic [31:0] PC_EX;
   logic        br_taken_EX;
   logic [31:0] br_target_EX;
   logic        predict_br_EX;
   logic        mispredict_EX;
   logic [31:0] PC_redirect_EX;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: entry valid, full PC-above-index stored for tag compare.
   bit          m_valid [64];
   int unsigned m_tag   [64];
   int unsigned m_tgt   [64];
   int          m_cnt   [256];

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk            (clk),
      .rst            (rst),
      .PC_IF          (PC_IF),
      .predict_br_IF  (predict_br_IF),
      .BHT_predict_IF (BHT_predict_IF),
      .PC_pred_IF     (PC_pred_IF),
      .update_en_EX   (update_en_EX),
      .PC_EX          (PC_EX),
      .br_taken_EX    (br_taken_EX),
      .br_target_EX   (br_target_EX),
      .predict_br_EX  (predict_br_EX),
      .mispredict_EX  (mispredict_EX),
      .PC_redirect_EX (PC_redirect_EX)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < 256; i++) m_cnt[i] = 1;
   endfunction

   // One cycle: apply inputs, compare every output to the model while the
   // tables still hold pre-edge state, then clock and advance the model.
   task automatic cycle(input bit r, input logic [31:0] pc_if, input bit en,
                        input logic [31:0] pc_ex, input bit tk,
                        input logic [31:0] tgt, input bit pex);
      int unsigned bi, hi, ei, ehi;
      bit          hit, pt;
      rst = r; PC_IF = pc_if; update_en_EX = en; PC_EX = pc_ex;
      br_taken_EX = tk; br_target_EX = tgt; predict_br_EX = pex;
      #1;
      bi  = (pc_if / 4) % 64;
      hi  = (pc_if / 4) % 256;
      hit = m_valid[bi] && (m_tag[bi] == pc_if / 256);
      pt  = hit && (m_cnt[hi] >= 2);
      if (!r) begin
         chk("bht_predict", BHT_predict_IF, 32'(m_cnt[hi] >= 2));
         chk("predict_br", predict_br_IF, 32'(pt));
         chk("pc_pred", PC_pred_IF, pt ? m_tgt[bi] : pc_if + 32'd4);
      end
      chk("mispredict", mispredict_EX, 32'(en && (pex != tk)));
      chk("redirect", PC_redirect_EX, tk ? tgt : pc_ex + 32'd4);
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (en) begin
         ei  = (pc_ex / 4) % 64;
         ehi = (pc_ex / 4) % 256;
         if (tk) begin
            m_cnt[ehi] = (m_cnt[ehi] == 3) ? 3 : m_cnt[ehi] + 1;
            m_valid[ei] = 1'b1;
            m_tag[ei]   = pc_ex / 256;
            m_tgt[ei]   = tgt;
         end else begin
            m_cnt[ehi] = (m_cnt[ehi] == 0) ? 0 : m_cnt[ehi] - 1;
         end
      end
      #1;
   endtask

   task automatic lookup(input logic [31:0] pc);
      cycle(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; PC_IF = '0; update_en_EX = 1'b0; PC_EX = '0;
      br_taken_EX = 1'b0; br_target_EX = '0; predict_br_EX = 1'b0;
      model_reset();
      @(posedge clk); #1;
      cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

      // Fresh reset: no prediction anywhere.
      lookup(32'h0000_1000);
      chk("r_pred", predict_br_IF, 32'd0);
      chk("r_bht", BHT_predict_IF, 32'd0);
      chk("r_pcpred", PC_pred_IF, 32'h0000_1004);

      // Train 0x1000 taken twice, looking it up in the same cycles.
      cycle(1'b0, 32'h1000, 1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0);
      cycle(1'b0, 32'h1000, 1'b1, 32'h1000, 1'b1, 32'h2000, 1'b1);
      lookup(32'h0000_1000);
      chk("trained_pred", predict_br_IF, 32'd1);
      chk("trained_tgt", PC_pred_IF, 32'h0000_2000);

      // Walk the counter down past the floor.
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 32'h1000, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0);
      lookup(32'h0000_1000);
      chk("floor_pred", predict_br_IF, 32'd0);

      // Tag conflict: 0x1100 evicts 0x1000 from the shared BTB slot.
      cycle(1'b0, 32'h1000, 1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0);
      cycle(1'b0, 32'h1000, 1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0);
      cycle(1'b0, 32'h1000, 1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0);
      cycle(1'b0, 32'h1000, 1'b1, 32'h1100, 1'b1, 32'h3000, 1'b0);
      lookup(32'h0000_1000);
      chk("evict_miss", predict_br_IF, 32'd0);
      lookup(32'h0000_1100);
      chk("evict_hit", predict_br_IF, 32'd1);
      chk("evict_tgt", PC_pred_IF, 32'h0000_3000);

      // Mispredict in both directions.
      cycle(1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0);

      // Wrap of PC+4 at the top of the address space.
      lookup(32'hFFFF_FFFC);

      // Reset beats a coincident update.
      cycle(1'b1, 32'h1100, 1'b1, 32'h1100, 1'b1, 32'h3000, 1'b0);
      lookup(32'h0000_1100);
      chk("rst_override", predict_br_IF, 32'd0);
      chk("rst_override_pc", PC_pred_IF, 32'h0000_1104);

      // Random traffic over a small PC pool so entries hit and alias.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] pa, pb;
         pa = {22'($urandom_range(0, 3)) << 2, 4'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
         pb = {22'($urandom_range(0, 3)) << 2, 4'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
         if ($urandom_range(0, 3) == 0) pa = pb;
         cycle($urandom_range(0, 199) == 0, pa, $urandom_range(0, 3) != 0, pb,
               1'($urandom), $urandom, 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BTB_IDX_W, default 6, meaning BTB index width (64 entries, index PC[7:2], tag PC[31:8]).
REQ-002 SHALL have parameter BHT_IDX_W, default 8, meaning BHT index width (256 two-bit counters, index PC[9:2]).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
PC_IF  in  32  fetch address to predict
predict_br_IF  out  1  predicted taken AND BTB hit; redirect fetch
BHT_predict_IF  out  1  BHT counter MSB for PC_IF, regardless of BTB hit
PC_pred_IF  out  32  predicted target when predict_br_IF=1, else PC_IF+4
update_en_EX  in  1  EX holds a valid conditional branch (caller gates with bubble/flush)
PC_EX  in  32  address of resolved branch
br_taken_EX  in  1  actual outcome
br_target_EX  in  32  actual taken target
predict_br_EX  in  1  predict_br_IF carried through the IF/ID and ID/EX segment registers
mispredict_EX  out  1  flush request for IF/ID and ID/EX
PC_redirect_EX  out  32  correct next PC when mispredict_EX=1

Function
REQ-005 Lookup SHALL be combinational from PC_IF and current table state; zero-cycle latency.
REQ-006 BTB hit SHALL mean valid[idx]=1 and tag[idx]=PC_IF[31:8]; an invalid or tag-mismatched entry is a miss.
REQ-007 predict_br_IF SHALL equal hit AND BHT[PC_IF[9:2]][1]; PC_pred_IF SHALL equal target[idx] if predict_br_IF, else PC_IF+4 (mod 2^32, wraps at 0xFFFFFFFC).
REQ-008 Update SHALL occur at the rising clk edge only when update_en_EX=1 and rst=0.
REQ-009 BHT update: counter +1 on taken, -1 on not-taken, saturating at 2'b11 and 2'b00.
REQ-010 BTB update on taken: write valid=1, tag=PC_EX[31:8], target=br_target_EX (replaces any prior occupant). On not-taken: BTB entry unchanged.
REQ-011 mispredict_EX SHALL be combinational: update_en_EX AND (predict_br_EX XOR br_taken_EX); 0 when update_en_EX=0.
REQ-012 PC_redirect_EX SHALL be br_target_EX if br_taken_EX else PC_EX+4.
REQ-013 Same-cycle lookup and update to the same index: lookup SHALL return the pre-update value; the new value is visible from the next cycle.
REQ-014 BTB and BHT indices are independent; aliasing in BHT (PC[9:2] collision) SHALL be permitted, BTB tag prevents wrong-target use.
REQ-015 PC_IF and PC_EX bits [1:0] SHALL be ignored.

Reset
REQ-016 While rst=1 at a clk edge: all BTB valid bits SHALL clear to 0 and all BHT counters SHALL set to 2'b01 (weakly not-taken); tags/targets need not be cleared.
REQ-017 After reset, predict_br_IF=0, BHT_predict_IF=0, PC_pred_IF=PC_IF+4 for every PC_IF.
REQ-018 rst=1 SHALL override a simultaneous update_en_EX=1; that update is discarded.
REQ-019 mispredict_EX and PC_redirect_EX are combinational and SHALL follow inputs during reset.

Structure
REQ-020 Table-size constants (BTB_IDX_W, BHT_IDX_W, tag width 32-BTB_IDX_W-2) and counter encodings (SNT=00, WNT=01, WT=10, ST=11) SHALL live in the shared core parameter header.
REQ-021 The saturating 2-bit counter next-state logic SHALL be one sub-module, sat_cnt2 (inputs cnt, taken; output next).
REQ-022 Tables SHALL be register arrays (no BRAM) to meet zero-cycle read.

Verification
REQ-023 Reset, then PC_IF=0x0000_1000 -> predict_br_IF=0, BHT_predict_IF=0, PC_pred_IF=0x0000_1004.
REQ-024 Two taken updates PC_EX=0x1000, target 0x2000 -> counter 01->10->11; PC_IF=0x1000 gives predict_br_IF=1, PC_pred_IF=0x2000.
REQ-025 Counter at 11, three not-taken updates -> 10,01,00; fourth stays 00; predict_br_IF=0 after second.
REQ-026 After 0x1000 trained, taken update PC_EX=0x1100 (same BTB idx, different tag) target 0x3000 -> PC_IF=0x1000 misses (predict_br_IF=0), 0x1100 hits with 0x3000.
REQ-027 update_en_EX=1, predict_br_EX=1, br_taken_EX=0, PC_EX=0x1000 -> mispredict_EX=1, PC_redirect_EX=0x1004; predict_br_EX=0, br_taken_EX=1 target 0x2000 -> mispredict_EX=1, PC_redirect_EX=0x2000.
REQ-028 Update and lookup same PC in one cycle -> old prediction that cycle, new next cycle; rst=1 with update_en_EX=1 -> table stays reset.
